// File: rtl/switch_input_driver.sv
// switch_input_driver
//  Memory-mapped input device on the CPU device bus. Samples 32 DIP switches
//  and 8 push-buttons, synchronises and debounces them, latches button-press
//  and switch-change events in STATUS and raises a maskable level interrupt.
// Ports
//  clk      system clock
//  reset    synchronous, active-high reset
//  Addr     byte address within the device window (Addr[1:0] ignored)
//  WE       write enable, sampled on posedge clk
//  Din      write data
//  Dout     read data, combinational from Addr
//  sw_pin   raw switch pins, asynchronous
//  btn_pin  raw button pins, asynchronous, 1 = pressed
//  irq      interrupt request, level, active-high, registered
// Register map (decoded only when Addr[7:4]==0)
//  0x00 SW RO, 0x04 BTN RO, 0x08 STATUS W1C, 0x0C IE RW

module switch_input_driver #(
   parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   input  logic [31:0] sw_pin,
   input  logic [7:0]  btn_pin,
   output logic        irq
);

   localparam int unsigned SW_W  = 32;
   localparam int unsigned BTN_W = 8;
   localparam int unsigned EVT_W = BTN_W + 1;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] REG_SW     = 2'd0;
   localparam logic [1:0] REG_BTN    = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_IE     = 2'd3;

   logic [SW_W-1:0]  sw_sync1, sw_sync2, sw_sync2_d, sw_stable;
   logic [BTN_W-1:0] btn_sync1, btn_sync2, btn_sync2_d, btn_stable;
   logic [CNT_W-1:0] sw_cnt, btn_cnt;
   logic [EVT_W-1:0] status, ie;

   logic             sw_hold, btn_hold;
   logic             sw_commit, btn_commit;
   logic             reg_sel, wr_status, wr_ie;
   logic [EVT_W-1:0] status_set, status_clr, status_nxt, ie_nxt;

   // Address bits below word granularity and unused data bits are don't-care.
   logic unused_bits;
   assign unused_bits = ^{Addr[1:0], Din[31:EVT_W]};

   // Two-flop synchronisers plus one extra stage for steadiness detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_sync1    <= '0;
         sw_sync2    <= '0;
         sw_sync2_d  <= '0;
         btn_sync1   <= '0;
         btn_sync2   <= '0;
         btn_sync2_d <= '0;
      end else begin
         sw_sync1    <= sw_pin;
         sw_sync2    <= sw_sync1;
         sw_sync2_d  <= sw_sync2;
         btn_sync1   <= btn_pin;
         btn_sync2   <= btn_sync1;
         btn_sync2_d <= btn_sync2;
      end
   end

   // A group counts only while its synchronised value is steady and differs
   // from the accepted value; any movement or a match restarts the window.
   assign sw_hold    = (sw_sync2 != sw_stable) && (sw_sync2 == sw_sync2_d);
   assign btn_hold   = (btn_sync2 != btn_stable) && (btn_sync2 == btn_sync2_d);
   assign sw_commit  = sw_hold && (sw_cnt == CNT_LAST);
   assign btn_commit = btn_hold && (btn_cnt == CNT_LAST);

   // Debounce counters and accepted values.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_cnt     <= '0;
         sw_stable  <= '0;
         btn_cnt    <= '0;
         btn_stable <= '0;
      end else begin
         if (!sw_hold) begin
            sw_cnt <= '0;
         end else if (sw_commit) begin
            sw_stable <= sw_sync2;
            sw_cnt    <= '0;
         end else begin
            sw_cnt <= sw_cnt + CNT_W'(1);
         end

         if (!btn_hold) begin
            btn_cnt <= '0;
         end else if (btn_commit) begin
            btn_stable <= btn_sync2;
            btn_cnt    <= '0;
         end else begin
            btn_cnt <= btn_cnt + CNT_W'(1);
         end
      end
   end

   // Register decode; set beats clear so an event arriving with a W1C is kept.
   always_comb begin
      reg_sel    = (Addr[7:4] == 4'd0);
      wr_status  = WE && reg_sel && (Addr[3:2] == REG_STATUS);
      wr_ie      = WE && reg_sel && (Addr[3:2] == REG_IE);
      status_set = '0;
      if (btn_commit) begin
         status_set[BTN_W-1:0] = btn_sync2 & ~btn_stable;
      end
      status_set[BTN_W] = sw_commit;
      status_clr = wr_status ? Din[EVT_W-1:0] : '0;
      status_nxt = (status & ~status_clr) | status_set;
      ie_nxt     = wr_ie ? Din[EVT_W-1:0] : ie;
   end

   // STATUS, IE and the interrupt flop; irq tracks the post-update registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         status <= '0;
         ie     <= '0;
         irq    <= 1'b0;
      end else begin
         status <= status_nxt;
         ie     <= ie_nxt;
         irq    <= |(status_nxt & ie_nxt);
      end
   end

   // Read mux.
   always_comb begin
      Dout = '0;
      if (reg_sel) begin
         case (Addr[3:2])
            REG_SW:     Dout = sw_stable;
            REG_BTN:    Dout = {24'd0, btn_stable};
            REG_STATUS: Dout = {23'd0, status};
            default:    Dout = {23'd0, ie};
         endcase
      end
   end

endmodule

// File: tb/tb_switch_input_driver.sv
// Self-checking bench for switch_input_driver with DEBOUNCE_CYCLES=4.
// The reference model keeps a short history of raw pin values per posedge and
// accepts a new value once the synchronised history has been identical for
// DEBOUNCE_CYCLES+1 samples and differs from the accepted value.

module tb_switch_input_driver;

   localparam int unsigned D  = 4;
   localparam int unsigned HL = D + 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic [31:0] sw_pin;
   logic [7:0]  btn_pin;
   logic        irq;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   logic [31:0] m_sw_h  [HL];
   logic [7:0]  m_btn_h [HL];
   logic [31:0] m_sw_stable;
   logic [7:0]  m_btn_stable;
   logic [8:0]  m_status;
   logic [8:0]  m_ie;

   always #5 clk = ~clk;

   switch_input_driver #(.DEBOUNCE_CYCLES(D)) dut (
      .clk     (clk),
      .reset   (reset),
      .Addr    (Addr),
      .WE      (WE),
      .Din     (Din),
      .Dout    (Dout),
      .sw_pin  (sw_pin),
      .btn_pin (btn_pin),
      .irq     (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] exp_dout(input logic [7:0] a);
      if (a[7:4] != 4'd0) return 32'd0;
      case (a[3:2])
         2'd0:    return m_sw_stable;
         2'd1:    return {24'd0, m_btn_stable};
         2'd2:    return {23'd0, m_status};
         default: return {23'd0, m_ie};
      endcase
   endfunction

   // Advance the model by one posedge using the inputs the DUT just sampled.
   task automatic model_clock();
      logic [8:0] set, clr;
      bit sw_c, btn_c;
      for (int i = HL - 1; i > 0; i--) begin
         m_sw_h[i]  = m_sw_h[i-1];
         m_btn_h[i] = m_btn_h[i-1];
      end
      m_sw_h[0]  = sw_pin;
      m_btn_h[0] = btn_pin;
      if (reset) begin
         for (int i = 0; i < HL; i++) begin
            m_sw_h[i]  = '0;
            m_btn_h[i] = '0;
         end
         m_sw_stable  = '0;
         m_btn_stable = '0;
         m_status     = '0;
         m_ie         = '0;
         return;
      end
      sw_c  = (m_sw_h[2] != m_sw_stable);
      btn_c = (m_btn_h[2] != m_btn_stable);
      for (int i = 3; i < HL; i++) begin
         if (m_sw_h[i] != m_sw_h[2])   sw_c  = 0;
         if (m_btn_h[i] != m_btn_h[2]) btn_c = 0;
      end
      set = '0;
      if (btn_c) set[7:0] = m_btn_h[2] & ~m_btn_stable;
      if (sw_c)  set[8]   = 1'b1;
      clr = '0;
      if (WE && Addr[7:4] == 4'd0 && Addr[3:2] == 2'd2) clr = Din[8:0];
      if (WE && Addr[7:4] == 4'd0 && Addr[3:2] == 2'd3) m_ie = Din[8:0];
      m_status = (m_status & ~clr) | set;
      if (sw_c)  m_sw_stable  = m_sw_h[2];
      if (btn_c) m_btn_stable = m_btn_h[2];
   endtask

   // One clock: model update, then check irq and every readable address.
   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      WE = 1'b0;
      chk("irq", {31'd0, irq}, {31'd0, |(m_status & m_ie)});
      for (int i = 0; i < 4; i++) begin
         Addr = 8'(i * 4 + int'($urandom_range(0, 3)));
         #1;
         chk($sformatf("rd_%02h", i * 4), Dout, exp_dout(Addr));
      end
      Addr = 8'($urandom_range(16, 255));
      #1;
      chk("rd_outside", Dout, exp_dout(Addr));
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] expv);
      Addr = a;
      #1;
      chk(tag, Dout, expv);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      Addr = a;
      Din  = d;
      WE   = 1'b1;
      step();
   endtask

   initial begin
      reset   = 1'b1;
      Addr    = '0;
      WE      = 1'b0;
      Din     = '0;
      sw_pin  = '0;
      btn_pin = '0;

      // Reset state.
      repeat (2) step();
      reset = 1'b0;
      step();
      rd("rst_sw", 8'h00, 32'h0);
      rd("rst_status", 8'h08, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'd0);

      // Switch change accepted on posedge 7.
      sw_pin = 32'hA5A5_0F0F;
      repeat (6) step();
      rd("sw_p6", 8'h00, 32'h0);
      step();
      rd("sw_p7", 8'h00, 32'hA5A5_0F0F);
      rd("sw_status_p7", 8'h08, 32'h100);

      // Bouncing button only accepted after a full steady window.
      wr(8'h08, 32'h100);
      btn_pin = 8'h04; step();
      btn_pin = 8'h00; step();
      btn_pin = 8'h04; step();
      btn_pin = 8'h00; step();
      btn_pin = 8'h04;
      repeat (6) step();
      rd("btn_p6", 8'h04, 32'h0);
      step();
      rd("btn_p7", 8'h04, 32'h4);
      rd("btn_status", 8'h08, 32'h4);

      // Interrupt enable, W1C and masking.
      wr(8'h0C, 32'h4);
      chk("irq_enabled", {31'd0, irq}, 32'd1);
      wr(8'h08, 32'h4);
      rd("status_cleared", 8'h08, 32'h0);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      wr(8'h0C, 32'h0);
      btn_pin = 8'h00;
      repeat (D + 4) step();
      rd("release_no_event", 8'h08, 32'h0);
      btn_pin = 8'h04;
      repeat (D + 4) step();
      rd("repress_status", 8'h08, 32'h4);
      chk("irq_masked", {31'd0, irq}, 32'd0);

      // Clear of bit 0 in the same cycle as its press commit: set wins.
      btn_pin = 8'h05;
      repeat (6) step();
      wr(8'h08, 32'h1);
      rd("set_wins", 8'h08, 32'h5);

      // Writes to read-only and out-of-window addresses are ignored.
      wr(8'h00, 32'hFFFF_FFFF);
      rd("sw_ro", 8'h00, 32'hA5A5_0F0F);
      rd("outside_zero", 8'h10, 32'h0);
      wr(8'h1C, 32'h1FF);
      rd("ie_alias_ignored", 8'h0C, 32'h0);

      // Reset in the middle of a button debounce window.
      btn_pin = 8'hC0;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      rd("midrst_btn", 8'h04, 32'h0);
      rd("midrst_status", 8'h08, 32'h0);
      repeat (D + 2) step();
      rd("postrst_btn_early", 8'h04, 32'h0);
      step();
      rd("postrst_btn", 8'h04, 32'hC0);
      rd("postrst_status", 8'h08, 32'h1C0);

      // Randomised traffic against the model.
      repeat (600) begin
         if ($urandom_range(0, 15) == 0) sw_pin = $urandom;
         if ($urandom_range(0, 7) == 0)  btn_pin = btn_pin ^ 8'(1 << $urandom_range(0, 7));
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) begin
            Addr = 8'($urandom_range(0, 31));
            Din  = $urandom;
            WE   = 1'b1;
         end
         step();
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
